univ_shift_reg_seq: RTL and testbench

Parametrised successor to the 24-bit universal shift register. Adds rotate, arithmetic-shift-right and clear modes, plus multi-bit shifts of AMT positions executed one bit per cycle. Commands are accepted through a valid/ready handshake and completion is signalled by a one-cycle DONE pulse. Sits in the datapath as a normaliser/serialiser feeding the arithmetic units.

---
 rtl/univ_shift_pkg.sv | 53 +++++
 rtl/univ_shift_ctrl.sv | 84 ++++++++
 rtl/univ_shift_reg_seq.sv | 72 +++++++
 tb/tb_univ_shift_reg_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_pkg.sv
// Shared types and the one-bit step function for the universal shift register.
package univ_shift_pkg;

    // Widest register the step function supports; the top zero-extends into it.
    localparam int C_MAX_BITS = 64;
    localparam int C_IDX_BITS = 6;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_SHL  = 3'd1,
        OP_SHR  = 3'd2,
        OP_LOAD = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5,
        OP_ASR  = 3'd6,
        OP_CLR  = 3'd7
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_t;

    // True for the operations that iterate AMT times.
    function automatic logic is_shift_op(input shift_op_t op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
               (op == OP_ROR) || (op == OP_ASR);
    endfunction

    // One-bit step of a register whose MSB sits at msb_idx. Bits above msb_idx
    // may hold garbage on return; the caller truncates to its own width.
    function automatic logic [C_MAX_BITS-1:0] shift_step(
        input logic [C_MAX_BITS-1:0] q,
        input shift_op_t             op,
        input logic                  sli,
        input logic                  sri,
        input logic [C_IDX_BITS-1:0] msb_idx
    );
        logic [C_MAX_BITS-1:0] res;
        res = q;
        case (op)
            OP_SHL: begin res = q << 1; res[0]       = sli;        end
            OP_SHR: begin res = q >> 1; res[msb_idx] = sri;        end
            OP_ROL: begin res = q << 1; res[0]       = q[msb_idx]; end
            OP_ROR: begin res = q >> 1; res[msb_idx] = q[0];       end
            OP_ASR: begin res = q >> 1; res[msb_idx] = q[msb_idx]; end
            default: res = q;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/univ_shift_ctrl.sv
// Command handshake, step counter and IDLE/SHIFT/DONE sequencing.
module univ_shift_ctrl
    import univ_shift_pkg::*;
#(
    parameter int C_AMT_BITS = 5
) (
    input  logic                  ck,
    input  logic                  rn,
    input  logic                  cmd_valid,
    input  logic [2:0]            op,
    input  logic [C_AMT_BITS-1:0] amt,
    output logic                  cmd_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  dp_en,
    output logic [2:0]            dp_op
);

    shift_state_t          state_q, state_d;
    shift_op_t             op_q, op_d;
    logic [C_AMT_BITS-1:0] cnt_q, cnt_d;
    shift_op_t             op_in;
    shift_op_t             dp_op_e;

    assign op_in = shift_op_t'(op);

    // Next-state, counter and datapath-enable decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        dp_en   = 1'b0;
        dp_op_e = op_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_in;
                    dp_op_e = op_in;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    if (is_shift_op(op_in)) begin
                        // The first step happens on the accept edge itself.
                        if (amt != '0) begin
                            dp_en = 1'b1;
                            cnt_d = amt - C_AMT_BITS'(1);
                            if (amt != C_AMT_BITS'(1)) state_d = ST_SHIFT;
                        end
                    end else begin
                        dp_en = (op_in == OP_LOAD) || (op_in == OP_CLR);
                    end
                end
            end
            ST_SHIFT: begin
                dp_en = 1'b1;
                cnt_d = cnt_q - C_AMT_BITS'(1);
                if (cnt_q == C_AMT_BITS'(1)) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge ck or negedge rn) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rn) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status comes straight from the state flops; CMD_VALID never reaches CMD_READY.
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign dp_op     = dp_op_e;

endmodule

// File: rtl/univ_shift_reg_seq.sv
// Universal shift register with multi-cycle shift/rotate commands over a
// valid/ready handshake. Supports widths from 2 up to 64 bits.
module univ_shift_reg_seq
    import univ_shift_pkg::*;
#(
    parameter int C_NUM_BITS = 24,
    parameter int C_AMT_BITS = $clog2(C_NUM_BITS) + 1
) (
    input  logic                  CK,
    input  logic                  RN,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [2:0]            OP,
    input  logic [C_AMT_BITS-1:0] AMT,
    input  logic [C_NUM_BITS-1:0] D,
    input  logic                  SLI,
    input  logic                  SRI,
    output logic [C_NUM_BITS-1:0] Q,
    output logic                  SLO,
    output logic                  SRO,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam logic [C_IDX_BITS-1:0] C_MSB_IDX = C_IDX_BITS'(C_NUM_BITS - 1);

    logic [C_NUM_BITS-1:0] q_q, q_d;
    logic                  dp_en;
    logic [2:0]            dp_op;
    shift_op_t             dp_op_e;

    univ_shift_ctrl #(
        .C_AMT_BITS (C_AMT_BITS)
    ) u_ctrl (
        .ck        (CK),
        .rn        (RN),
        .cmd_valid (CMD_VALID),
        .op        (OP),
        .amt       (AMT),
        .cmd_ready (CMD_READY),
        .busy      (BUSY),
        .done      (DONE),
        .dp_en     (dp_en),
        .dp_op     (dp_op)
    );

    assign dp_op_e = shift_op_t'(dp_op);

    // Load/clear/step mux; the register holds whenever the controller does not enable it.
    always_comb begin
        q_d = q_q;
        if (dp_en) begin
            case (dp_op_e)
                OP_LOAD: q_d = D;
                OP_CLR:  q_d = '0;
                default: q_d = C_NUM_BITS'(shift_step(C_MAX_BITS'(q_q), dp_op_e, SLI, SRI, C_MSB_IDX));
            endcase
        end
    end

    // Datapath register.
    always_ff @(posedge CK or negedge RN) begin
        // NOTE: Q is a plain register, not a memory, so it takes the async reset like the control flops.
        if (!RN) q_q <= '0;
        else     q_q <= q_d;
    end

    assign Q   = q_q;
    assign SLO = q_q[C_NUM_BITS-1];
    assign SRO = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// Directed bench for univ_shift_reg_seq at 8 bits.
module tb_univ_shift_reg_seq;
    import univ_shift_pkg::*;

    localparam int N  = 8;
    localparam int AW = 4;

    logic          CK = 1'b0;
    logic          RN;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic [2:0]    OP;
    logic [AW-1:0] AMT;
    logic [N-1:0]  D;
    logic          SLI;
    logic          SRI;
    logic [N-1:0]  Q;
    logic          SLO;
    logic          SRO;
    logic          BUSY;
    logic          DONE;

    int n_checks = 0;
    int n_errors = 0;

    univ_shift_reg_seq #(
        .C_NUM_BITS (N),
        .C_AMT_BITS (AW)
    ) dut (
        .CK        (CK),
        .RN        (RN),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .OP        (OP),
        .AMT       (AMT),
        .D         (D),
        .SLI       (SLI),
        .SRI       (SRI),
        .Q         (Q),
        .SLO       (SLO),
        .SRO       (SRO),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Present a command for exactly one edge (the block is IDLE when called).
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] amt, input logic [N-1:0] d);
        CMD_VALID = 1'b1;
        OP        = op;
        AMT       = amt;
        D         = d;
        tick();
        CMD_VALID = 1'b0;
    endtask

    // Count edges until DONE, bounded so a stuck controller still reaches the summary.
    task automatic wait_done(input string tag, input int exp_ticks);
        int n;
        n = 0;
        while (DONE !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, n, exp_ticks);
    endtask

    initial begin
        int seen_done;

        RN = 1'b0; CMD_VALID = 1'b0; OP = 3'd0; AMT = '0; D = '0; SLI = 1'b0; SRI = 1'b0;
        #12;
        check("rst_q",     Q,         32'h00);
        check("rst_ready", CMD_READY, 32'h1);
        check("rst_busy",  BUSY,      32'h0);
        check("rst_done",  DONE,      32'h0);
        RN = 1'b1;

        // LOAD then SHL by 3 with SLI held high.
        issue(OP_LOAD, 4'd0, 8'hA5);
        check("load_q",     Q,         32'hA5);
        check("load_done",  DONE,      32'h1);
        check("load_ready", CMD_READY, 32'h0);
        tick();
        check("load_idle",  CMD_READY, 32'h1);
        SLI = 1'b1;
        issue(OP_SHL, 4'd3, 8'h00);
        check("shl_s1",     Q,         32'h4B);
        check("shl_s1_rdy", CMD_READY, 32'h0);
        check("shl_s1_bsy", BUSY,      32'h1);
        tick();
        check("shl_s2",     Q,         32'h97);
        check("shl_s2_rdy", CMD_READY, 32'h0);
        check("shl_s2_dn",  DONE,      32'h0);
        tick();
        check("shl_s3",     Q,         32'h2F);
        check("shl_done",   DONE,      32'h1);
        check("shl_s3_rdy", CMD_READY, 32'h0);
        check("shl_slo",    SLO,       32'h0);
        check("shl_sro",    SRO,       32'h1);
        tick();
        check("shl_idle_q",  Q,         32'h2F);
        check("shl_idle_dn", DONE,      32'h0);
        check("shl_idle_rd", CMD_READY, 32'h1);

        // ROR by 9 wraps to ROR by 1; ROL by 8 is identity.
        issue(OP_LOAD, 4'd0, 8'hA5); tick();
        issue(OP_ROR, 4'd9, 8'h00);
        wait_done("ror9_steps", 8);
        check("ror9_q", Q, 32'hD2);
        tick();
        issue(OP_LOAD, 4'd0, 8'hA5); tick();
        issue(OP_ROL, 4'd8, 8'h00);
        wait_done("rol8_steps", 7);
        check("rol8_q", Q, 32'hA5);
        tick();

        // ASR fills with the sign; SHR takes a per-edge serial stream.
        issue(OP_LOAD, 4'd0, 8'h80); tick();
        issue(OP_ASR, 4'd4, 8'h00);
        wait_done("asr4_steps", 3);
        check("asr4_q", Q, 32'hF8);
        tick();
        SRI = 1'b0;
        issue(OP_SHR, 4'd2, 8'h00);
        check("shr_s1", Q, 32'h7C);
        SRI = 1'b1;
        tick();
        check("shr_s2",   Q,    32'hBE);
        check("shr_done", DONE, 32'h1);
        tick();

        // Zero-length shift: Q untouched, DONE right after accept.
        issue(OP_LOAD, 4'd0, 8'h3C); tick();
        issue(OP_SHR, 4'd0, 8'h00);
        check("amt0_q",    Q,    32'h3C);
        check("amt0_done", DONE, 32'h1);
        tick();
        check("amt0_idle_bsy", BUSY,      32'h0);
        check("amt0_idle_rdy", CMD_READY, 32'h1);
        check("amt0_idle_dn",  DONE,      32'h0);

        // NOP ignores AMT and D.
        issue(OP_NOP, 4'd5, 8'h11);
        check("nop_q",    Q,    32'h3C);
        check("nop_done", DONE, 32'h1);
        tick();

        // Async reset in the middle of a shift.
        issue(OP_LOAD, 4'd0, 8'hFF); tick();
        SLI = 1'b0;
        issue(OP_SHL, 4'd6, 8'h00);
        check("rstmid_s1", Q, 32'hFE);
        tick();
        check("rstmid_s2", Q, 32'hFC);
        RN = 1'b0;
        #1;
        check("rstmid_q",     Q,         32'h00);
        check("rstmid_busy",  BUSY,      32'h0);
        check("rstmid_ready", CMD_READY, 32'h1);
        check("rstmid_done",  DONE,      32'h0);
        #2;
        RN = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (DONE === 1'b1) seen_done++;
        end
        check("rstmid_no_done", seen_done, 0);
        check("rstmid_q_hold",  Q,         32'h00);

        // CLR held on CMD_VALID during ROL by 3 is accepted only once IDLE.
        issue(OP_LOAD, 4'd0, 8'h81); tick();
        issue(OP_ROL, 4'd3, 8'h00);
        check("hold_s1", Q, 32'h03);
        CMD_VALID = 1'b1; OP = OP_CLR; AMT = 4'd0; D = 8'h55;
        tick();
        check("hold_s2",     Q,         32'h06);
        check("hold_s2_rdy", CMD_READY, 32'h0);
        tick();
        check("hold_s3",     Q,         32'h0C);
        check("hold_s3_dn",  DONE,      32'h1);
        tick();
        check("hold_idle_q",  Q,         32'h0C);
        check("hold_idle_rd", CMD_READY, 32'h1);
        tick();
        CMD_VALID = 1'b0;
        check("hold_clr_q",  Q,    32'h00);
        check("hold_clr_dn", DONE, 32'h1);
        tick();
        check("hold_end_rdy", CMD_READY, 32'h1);
        check("hold_end_dn",  DONE,      32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
